// File: rtl/sensor_init_pkg.sv
// Shared definitions for the sensor initialisation sequencer: FSM state
// encodings, table row layout and the default register-write table.
package sensor_init_pkg;

    // Row layout: {dev_address[6:0], reg_address[7:0], data[7:0]}
    localparam int ROW_W      = 23;
    localparam int MAX_TABLE  = 32;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_LOAD          = 3'd1,
        S_ISSUE         = 3'd2,
        S_WAIT_ACCEPT   = 3'd3,
        S_WAIT_COMPLETE = 3'd4,
        S_SETTLE        = 3'd5,
        S_DONE          = 3'd6,
        S_ERROR         = 3'd7
    } state_e;

    // Cycles the write engine gets to leave idle after a start pulse
    localparam int ACCEPT_TIMEOUT = 4;

    // Default bring-up table: soft reset, then clock/format/enable writes,
    // remaining slots walk a block of configuration registers with zeros.
    function automatic logic [ROW_W-1:0] default_row(input logic [4:0] idx);
        logic [ROW_W-1:0] row;
        case (idx)
            5'd0:    row = {7'h36, 8'h00, 8'h01};
            5'd1:    row = {7'h36, 8'h10, 8'h2A};
            5'd2:    row = {7'h36, 8'h11, 8'h55};
            5'd3:    row = {7'h36, 8'h12, 8'h80};
            5'd4:    row = {7'h36, 8'h20, 8'h03};
            5'd5:    row = {7'h36, 8'h21, 8'h0F};
            5'd6:    row = {7'h36, 8'h30, 8'hC4};
            5'd7:    row = {7'h36, 8'h01, 8'h01};
            default: row = {7'h36, 8'h40 + {3'b000, idx}, 8'h00};
        endcase
        return row;
    endfunction

endpackage

// File: rtl/sensor_init_rom.sv
// Combinational table lookup: entry index -> {dev, reg, data}.
// Indices at or beyond NUM_ENTRIES read back as all zeros.
module sensor_init_rom
    import sensor_init_pkg::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [4:0] index,
    output logic [6:0] dev_address,
    output logic [7:0] reg_address,
    output logic [7:0] data
);

    logic [ROW_W-1:0] row;

    // Table lookup with out-of-range guard
    always_comb begin
        row = '0;
        if (32'(index) < 32'(NUM_ENTRIES)) begin
            row = default_row(index);
        end
        {dev_address, reg_address, data} = row;
    end

endmodule

// File: rtl/sensor_init_sequencer.sv
// Walks the register-write table, launching one write-engine transaction
// per entry with a settle gap between writes and a watchdog per write.
// Optional macro SENSOR_INIT_RETRY_EN: failed attempts are retried up to
// MAX_RETRIES times before the sequence stops in ERROR.
//
// Handshake with the write engine: wr_start is a one-cycle pulse, only
// given while wr_idle=1; the engine accepts by dropping wr_idle and
// completes by raising wr_idle again; wr_failure seen at any point before
// or together with that rising wr_idle marks the attempt as failed.
module sensor_init_sequencer
    import sensor_init_pkg::*;
#(
    parameter int NUM_ENTRIES     = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int SETTLE_CYCLES   = 1000,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_start,
    input  logic       wr_idle,
    input  logic       wr_failure,
    output logic       wr_start,
    output logic [6:0] wr_dev_address,
    output logic [7:0] wr_reg_address,
    output logic [7:0] wr_data,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [4:0] entry_index,
    output logic [2:0] state_out
);

    localparam logic [4:0] LAST_ENTRY = 5'(NUM_ENTRIES - 1);

    state_e      state_q, state_d;
    logic [4:0]  entry_q, entry_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fail_flag_q, fail_flag_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        attempt_fail;
    logic [31:0] cnt_next;
    logic [15:0] cnt_sat;
    logic [6:0]  rom_dev;
    logic [7:0]  rom_reg;
    logic [7:0]  rom_data;

`ifdef SENSOR_INIT_RETRY_EN
    // A 2-bit counter cannot count past 3, so larger limits clamp there
    localparam int RETRY_LIMIT = (MAX_RETRIES > 3) ? 3 : MAX_RETRIES;
    logic [1:0] retry_q, retry_d;
`endif

    sensor_init_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
        .index       (entry_q),
        .dev_address (rom_dev),
        .reg_address (rom_reg),
        .data        (rom_data)
    );

    // Shared settle/watchdog/accept counter value for "this cycle counted"
    assign cnt_next = 32'(cnt_q) + 32'd1;
    assign cnt_sat  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: entry, counters, failure flag and write operands
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entry_q     <= '0;
            cnt_q       <= '0;
            fail_flag_q <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            data_q      <= '0;
`ifdef SENSOR_INIT_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            fail_flag_q <= fail_flag_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
`ifdef SENSOR_INIT_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        fail_flag_d  = fail_flag_q;
        dev_d        = dev_q;
        reg_d        = reg_q;
        data_d       = data_q;
        attempt_fail = 1'b0;
`ifdef SENSOR_INIT_RETRY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (init_start) begin
                    state_d = S_LOAD;
                    entry_d = '0;
`ifdef SENSOR_INIT_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            S_LOAD: begin
                dev_d   = rom_dev;
                reg_d   = rom_reg;
                data_d  = rom_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (wr_idle) begin
                    state_d = S_WAIT_ACCEPT;
                end
            end
            S_WAIT_ACCEPT: begin
                cnt_d = cnt_sat;
                if (!wr_idle) begin
                    state_d = S_WAIT_COMPLETE;
                end else if (cnt_next >= 32'(ACCEPT_TIMEOUT)) begin
                    attempt_fail = 1'b1;
                end
            end
            S_WAIT_COMPLETE: begin
                cnt_d = cnt_sat;
                if (wr_failure) begin
                    fail_flag_d = 1'b1;
                end
                if (wr_idle) begin
                    if (fail_flag_q || wr_failure) begin
                        attempt_fail = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else if (cnt_next >= 32'(WATCHDOG_CYCLES)) begin
                    attempt_fail = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_sat;
                if (cnt_next >= 32'(SETTLE_CYCLES)) begin
                    if (entry_q == LAST_ENTRY) begin
                        state_d = S_DONE;
                    end else begin
                        entry_d = entry_q + 5'd1;
                        state_d = S_LOAD;
`ifdef SENSOR_INIT_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (attempt_fail) begin
`ifdef SENSOR_INIT_RETRY_EN
            if (32'(retry_q) < 32'(RETRY_LIMIT)) begin
                retry_d = (retry_q == 2'b11) ? retry_q : retry_q + 2'd1;
                state_d = S_LOAD;
            end else begin
                state_d = S_ERROR;
            end
`else
            state_d = S_ERROR;
`endif
        end

        // Every state starts with a fresh counter and a clear failure flag
        if (state_d != state_q) begin
            cnt_d       = '0;
            fail_flag_d = 1'b0;
        end
    end

    // Outputs decoded from the current state and registers
    always_comb begin
        wr_start       = (state_q == S_ISSUE) && wr_idle;
        wr_dev_address = dev_q;
        wr_reg_address = reg_q;
        wr_data        = data_q;
        init_busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
        init_done      = (state_q == S_DONE);
        init_error     = (state_q == S_ERROR);
        entry_index    = entry_q;
        state_out      = state_q;
    end

endmodule
